// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-port AXI SRAM slave, one transaction in flight; `define AXI_SLV_DELAY_EN adds LFSR-timed handshake stalls
module axi_sram_slave #(
    parameter int DEPTH_LOG2 = 12,
    parameter int ID_W       = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);
    localparam int AW = DEPTH_LOG2;

    typedef enum logic [2:0] {INIT, IDLE, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d, nxt_addr;
    logic [7:0]      cnt_q, cnt_d;
    logic            fixed_q, fixed_d;
    logic [ID_W-1:0] rid_q, rid_d, bid_q, bid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic            bvalid_q, bvalid_d, err_q, err_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [31:0]     mem [2**AW];
    logic            go, ar_hs, aw_hs, w_hs, r_hs, unused_ok;

`ifdef AXI_SLV_DELAY_EN
    logic [7:0] lfsr_q;
    logic [1:0] dly_q;
    // Free-running LFSR; every handshake reloads a 0-3 cycle stall before the next ready/valid
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_q <= 8'hA5;
            dly_q  <= 2'd0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            dly_q  <= (ar_hs || aw_hs || w_hs || r_hs) ? lfsr_q[1:0] : (dly_q != 2'd0 ? dly_q - 2'd1 : 2'd0);
        end
    end
    assign go = (dly_q == 2'd0);
`else
    assign go = 1'b1;
`endif

    assign arready   = (state_q == IDLE) && go;
    assign awready   = (state_q == IDLE) && !arvalid && go;
    assign wready    = (state_q == WR_DATA) && go;
    assign rvalid    = rvalid_q && go;
    assign rid       = rid_q;
    assign rdata     = rdata_q;
    assign rresp     = 2'b00;
    assign rlast     = rlast_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign bvalid    = bvalid_q;
    assign ar_hs     = arvalid && arready;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign r_hs      = rvalid && rready;
    assign nxt_addr  = fixed_q ? addr_q : addr_q + AW'(1);
    assign unused_ok = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};

    // State and datapath registers; memory contents are deliberately left out of reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= INIT;
            addr_q   <= '0;
            cnt_q    <= '0;
            fixed_q  <= 1'b0;
            rid_q    <= '0;
            bid_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            fixed_q  <= fixed_d;
            rid_q    <= rid_d;
            bid_q    <= bid_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            bvalid_q <= bvalid_d;
            err_q    <= err_d;
            bresp_q  <= bresp_d;
        end
    end

    // FSM next state plus burst address/counter, read data and write response updates
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        fixed_d  = fixed_q;
        rid_d    = rid_q;
        bid_d    = bid_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        bvalid_d = bvalid_q;
        err_d    = err_q;
        bresp_d  = bresp_q;
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (ar_hs) begin
                    rid_d    = arid;
                    addr_d   = araddr[AW+1:2];
                    cnt_d    = arlen;
                    fixed_d  = (arburst == 2'b00);
                    rdata_d  = mem[araddr[AW+1:2]];
                    rvalid_d = 1'b1;
                    rlast_d  = (arlen == 8'd0);
                    state_d  = RD_DATA;
                end else if (aw_hs) begin
                    bid_d   = awid;
                    addr_d  = awaddr[AW+1:2];
                    cnt_d   = awlen;
                    fixed_d = (awburst == 2'b00);
                    err_d   = 1'b0;
                    state_d = WR_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs && rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = IDLE;
                end else if (r_hs) begin
                    addr_d  = nxt_addr;
                    rdata_d = mem[nxt_addr];
                    cnt_d   = cnt_q - 8'd1;
                    rlast_d = (cnt_q == 8'd1);
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    addr_d = nxt_addr;
                    cnt_d  = cnt_q - 8'd1;
                    err_d  = err_q || (wlast != (cnt_q == 8'd0));
                    if (cnt_q == 8'd0) begin
                        bvalid_d = 1'b1;
                        bresp_d  = err_d ? 2'b10 : 2'b00;
                        state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Byte-enabled write of each accepted W beat at the current burst address
    always_ff @(posedge aclk) begin
        if (aresetn && w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[addr_q][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table-driven write/read-back vectors plus scoreboarded burst, arbitration and reset sequences
module tb_axi_sram_slave;
    localparam int IW = 4;

    logic          aclk = 1'b0, aresetn = 1'b0;
    logic [IW-1:0] arid = '0, awid = '0, rid, bid;
    logic [31:0]   araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic [7:0]    arlen = '0, awlen = '0;
    logic [1:0]    arburst = 2'b01, awburst = 2'b01, rresp, bresp;
    logic [3:0]    wstrb = '0;
    logic          arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic          rready = 1'b0, bready = 1'b0;
    logic          arready, awready, wready, rvalid, rlast, bvalid;

    typedef struct packed {
        logic [31:0]   d;
        logic          l;
        logic [IW-1:0] id;
    } rexp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] e;
    } vec_t;

    rexp_t       sb[$];
    rexp_t       me, te;
    logic [31:0] mdl [4096];
    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    logic [31:0] hold_v;
    int          total = 0, bad = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.DEPTH_LOG2(12), .ID_W(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return arready;
            1: return awready;
            2: return wready;
            3: return bvalid;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_hi(input int w, input string nm);
        int n = 0;
        @(negedge aclk);
        while (!sig(w) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!sig(w)) begin
            total++;
            bad++;
            $display("FAIL %s: still low after %0d cycles, expected high", nm, n);
        end
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [7:0] len, input logic [IW-1:0] id, input logic [1:0] bu);
        rexp_t e;
        logic [11:0] ix;
        for (int i = 0; i <= int'(len); i++) begin
            ix   = a[13:2] + (bu == 2'b00 ? 12'd0 : 12'(i));
            e.d  = mdl[ix];
            e.l  = (i == int'(len));
            e.id = id;
            sb.push_back(e);
        end
    endtask

    task automatic ar_go(input logic [31:0] a, input logic [7:0] len, input logic [IW-1:0] id, input logic [1:0] bu);
        arid    = id;
        araddr  = a;
        arlen   = len;
        arburst = bu;
        arvalid = 1'b1;
        wait_hi(0, "arready");
        tick();
        arvalid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: %0d read beats missing, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [IW-1:0] id, input logic [1:0] bu, input string nm);
        push_rd(a, len, id, bu);
        rready = 1'b1;
        ar_go(a, len, id, bu);
        drain(nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [IW-1:0] id, input int lb, input logic [1:0] er, input string nm);
        logic [11:0] ix;
        awid    = id;
        awaddr  = a;
        awlen   = len;
        awburst = 2'b01;
        awvalid = 1'b1;
        wait_hi(1, {nm, "_awready"});
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == lb);
            wvalid = 1'b1;
            wait_hi(2, {nm, "_wready"});
            ix = a[13:2] + 12'(i);
            for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[ix][8*b +: 8] = wd[i][8*b +: 8];
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        wait_hi(3, {nm, "_bvalid"});
        chk({nm, "_bresp"}, 32'(bresp), 32'(er));
        chk({nm, "_bid"}, 32'(bid), 32'(id));
        tick();
        bready = 1'b0;
    endtask

    // Scoreboard: every read beat handshake pops the next expected beat
    always @(negedge aclk) begin
        if (aresetn && rvalid && rready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rbeat: unexpected beat rdata=%h, expected none", rdata);
            end else begin
                me = sb.pop_front();
                chk("rdata", rdata, me.d);
                chk("rlast", 32'(rlast), 32'(me.l));
                chk("rid", 32'(rid), 32'(me.id));
                chk("rresp", 32'(rresp), 32'd0);
            end
        end
    end

    initial begin
        vec_t tv [8];
        tv[0] = '{32'h0000_0020, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        tv[1] = '{32'h0000_0020, 32'h00001234, 4'h3, 32'hDEAD1234};
        tv[2] = '{32'h0000_4020, 32'h77000000, 4'h8, 32'h77AD1234};
        tv[3] = '{32'h0000_0024, 32'h00000000, 4'hF, 32'h00000000};
        tv[4] = '{32'h0000_0024, 32'hFFFFFFFF, 4'h5, 32'h00FF00FF};
        tv[5] = '{32'h0000_3FFC, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
        tv[6] = '{32'h0000_0000, 32'h0BADF00D, 4'hF, 32'h0BADF00D};
        tv[7] = '{32'h0000_8010, 32'h0000AB00, 4'h2, 32'h1122AB44};

        repeat (3) tick();
        @(negedge aclk);
        chk("rst_ready", 32'({arready, awready, wready}), 32'd0);
        chk("rst_valid", 32'({rvalid, bvalid, rlast}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ids", 32'({rid, bid, bresp, rresp}), 32'd0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("init_arready", 32'(arready), 32'd0);
        @(negedge aclk);
        chk("idle_arready", 32'(arready), 32'd1);
        chk("idle_awready", 32'(awready), 32'd1);
        tick();

        wd[0] = 32'h11223344;
        ws[0] = 4'hF;
        wr(32'h10, 8'd0, 4'd3, 0, 2'b00, "w10");
        te.d  = 32'h11223344;
        te.l  = 1'b1;
        te.id = 4'd5;
        sb.push_back(te);
        rready  = 1'b1;
        arid    = 4'd5;
        araddr  = 32'h10;
        arlen   = 8'd0;
        arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge aclk);
        chk("t1_arready", 32'(arready), 32'd1);
        chk("t1_rvalid_pre", 32'(rvalid), 32'd0);
        tick();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("t1_rvalid", 32'(rvalid), 32'd1);
        chk("t1_rlast", 32'(rlast), 32'd1);
        tick();
        @(negedge aclk);
        chk("t1_rvalid_done", 32'(rvalid), 32'd0);
        tick();
        drain("t1");

        for (int i = 0; i < 8; i++) begin
            wd[0] = tv[i].d;
            ws[0] = tv[i].s;
            wr(tv[i].a, 8'd0, 4'(i), 0, 2'b00, $sformatf("tv%0d", i));
            te.d  = tv[i].e;
            te.l  = 1'b1;
            te.id = 4'(i + 8);
            sb.push_back(te);
            rready = 1'b1;
            ar_go(tv[i].a, 8'd0, 4'(i + 8), 2'b01);
            drain($sformatf("tv%0d_rd", i));
        end

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1);
            ws[i] = 4'hF;
        end
        wr(32'h100, 8'd3, 4'd2, 3, 2'b00, "wburst");
        push_rd(32'h100, 8'd3, 4'd6, 2'b01);
        rready = 1'b1;
        ar_go(32'h100, 8'd3, 4'd6, 2'b01);
        tick();
        rready = 1'b0;
        @(negedge aclk);
        hold_v = rdata;
        chk("hold_rvalid", 32'(rvalid), 32'd1);
        chk("hold_rlast", 32'(rlast), 32'd0);
        tick();
        rready = 1'b1;
        @(negedge aclk);
        chk("hold_rdata", rdata, hold_v);
        chk("hold_beat2", rdata, 32'd2);
        drain("toggle");

        rd(32'h104, 8'd1, 4'd7, 2'b00, "fixed");
        rd(32'h3FFC, 8'd1, 4'd9, 2'b01, "wrap");

        push_rd(32'h100, 8'd0, 4'd1, 2'b01);
        rready  = 1'b1;
        arid    = 4'd1;
        araddr  = 32'h100;
        arlen   = 8'd0;
        arburst = 2'b01;
        arvalid = 1'b1;
        awid    = 4'd2;
        awaddr  = 32'h200;
        awlen   = 8'd0;
        awburst = 2'b01;
        awvalid = 1'b1;
        @(negedge aclk);
        chk("both_arready", 32'(arready), 32'd1);
        chk("both_awready", 32'(awready), 32'd0);
        tick();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rd_busy_awready", 32'(awready), 32'd0);
        chk("rd_busy_rvalid", 32'(rvalid), 32'd1);
        tick();
        drain("both_rd");
        wd[0] = 32'h55AA55AA;
        ws[0] = 4'hF;
        wr(32'h200, 8'd0, 4'd2, 0, 2'b00, "after_rd");
        rd(32'h200, 8'd0, 4'd3, 2'b01, "after_rd_chk");

        wd[0] = 32'hA1A1A1A1;
        wd[1] = 32'hA2A2A2A2;
        ws[0] = 4'hF;
        ws[1] = 4'hF;
        wr(32'h300, 8'd1, 4'd4, 0, 2'b10, "early_wlast");
        rd(32'h300, 8'd1, 4'd4, 2'b01, "early_wlast_rd");
        wd[0] = 32'h0F0F0F0F;
        wr(32'h308, 8'd0, 4'd5, -1, 2'b10, "no_wlast");

        push_rd(32'h100, 8'd3, 4'd5, 2'b01);
        rready = 1'b1;
        ar_go(32'h100, 8'd3, 4'd5, 2'b01);
        tick();
        aresetn = 1'b0;
        tick();
        @(negedge aclk);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_arready", 32'(arready), 32'd0);
        sb.delete();
        tick();
        aresetn = 1'b1;
        rd(32'h104, 8'd0, 4'd5, 2'b01, "post_rst");
        rd(32'h20, 8'd0, 4'd6, 2'b01, "post_rst_keep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Single-port AXI slave memory model that sits directly downstream of the CPU's AXI master port and serves both instruction and data traffic.
- Used as the memory behind mycpu_top in the lab SoC and for standalone bridge verification.
- One read or one write transaction in flight at a time; INCR/FIXED bursts supported; byte-enabled writes.

Parameters:
DEPTH_LOG2, 12, memory holds 2**DEPTH_LOG2 32-bit words; word index = addr[DEPTH_LOG2+1:2], upper address bits alias
ID_W, 4, width of arid/rid/awid/bid

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous active-low reset
arid  in  ID_W  read transaction id
araddr  in  32  read start byte address
arlen  in  8  read beats minus 1
arburst  in  2  2'b00 FIXED, 2'b01 INCR, 2'b10 WRAP (treated as INCR)
arvalid  in  1  read address valid
arready  out  1  read address accept
rid  out  ID_W  echo of accepted arid
rdata  out  32  read beat data
rresp  out  2  always 2'b00
rlast  out  1  final read beat
rvalid  out  1  read data valid
rready  in  1  master accepts read beat
awid  in  ID_W  write transaction id
awaddr  in  32  write start byte address
awlen  in  8  write beats minus 1
awburst  in  2  as arburst
awvalid  in  1  write address valid
awready  out  1  write address accept
wdata  in  32  write beat data
wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
wlast  in  1  master's last-beat flag
wvalid  in  1  write data valid
wready  out  1  write data accept
bid  out  ID_W  echo of accepted awid
bresp  out  2  2'b00 OKAY or 2'b10 SLVERR
bvalid  out  1  write response valid
bready  in  1  master accepts response

Behaviour:
- Size, lock, cache, prot and wid are not ports; every beat is a full 32-bit word.
- Reset (aresetn=0 at edge): state<=INIT. All outputs are 0, including rdata, rid, bid, rlast and bresp. Memory contents are not reset.
- FSM states: INIT, IDLE, RD_DATA, WR_DATA, WR_RESP.
- INIT: exits to IDLE after one cycle; all ready signals 0.
- Ready outputs:
  - arready = (state==IDLE).
  - awready = (state==IDLE) && !arvalid; reads win simultaneous requests.
  - wready = (state==WR_DATA).
- Read:
  - On the AR handshake edge: latch rid, address, arlen into a beat counter, and arburst; rdata<=mem[idx(araddr)]; rvalid<=1; rlast<=(arlen==0); go to RD_DATA. rvalid therefore rises the cycle after the handshake.
  - RD_DATA with rready=0: rvalid, rdata and rlast hold.
  - RD_DATA with rready=1 on a non-last beat: address advances (+4 for INCR/WRAP, unchanged for FIXED); rdata<=mem[next]; counter decrements; rvalid stays 1, giving back-to-back beats.
  - RD_DATA with rready=1 on the last beat: rvalid<=0, rlast<=0, state<=IDLE.
- Write:
  - On the AW handshake: latch bid, address, awlen into the counter, and awburst; clear the err flag; go to WR_DATA.
  - Each W handshake writes the bytes enabled by wstrb at the current address, then advances the address and decrements the counter.
  - err is set if wlast != (counter==0) on any beat.
  - Burst length is set by the counter only; wlast never ends a burst.
  - On the final beat: bvalid<=1, bresp<=err ? 2'b10 : 2'b00, state<=WR_RESP.
- WR_RESP: bvalid holds until bready, then bvalid<=0 and state<=IDLE.
- Address wrap: the word index wraps modulo depth, with no error.
- Reset mid-burst: the transaction is abandoned, beats already written stay in memory, and no response is issued.
- Reads never observe partial writes, since transactions are serialized.

Optional Feature:
AXI_SLV_DELAY_EN
- Defined: an 8-bit LFSR (seed 8'hA5, taps 8,6,5,4) advances every cycle. Before each arready/awready assertion, each rvalid beat and each wready beat, the slave waits LFSR[1:0] extra cycles (0-3) with that signal held 0. Data ordering and values are unchanged.
- Undefined: zero added delay; timing exactly as in Behaviour.

Test Plan:
- Reset, then read at araddr=0x10 with arlen=0 and rready=1 -> arready=1 from the second cycle after reset release. rvalid=1 and rlast=1 with word 4's data the cycle after the handshake. rresp=0; rid echoes arid.
- Write 0xDEADBEEF to 0x20 with wstrb=4'b1111, then write 0x00001234 with wstrb=4'b0011, then read 0x20 -> rdata=0xDEAD1234; bresp=0 both times.
- INCR read at 0x100 with arlen=3 over preloaded words 1..4, rready toggling 1,0,1,1,1 -> beats 1,2,3,4 in order. Data holds while rready=0; rlast only on beat 4.
- arvalid and awvalid asserted in the same cycle -> read handshake first with awready=0; write accepted only after the read burst completes.
- Write with awlen=1 but wlast=1 on beat 1 -> both beats written, bresp=2'b10.
- aresetn=0 during beat 2 of a 4-beat read -> next cycle rvalid=0 and arready=0. After release, a new read returns correct data.
